// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment check used when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory bus of the load/store unit.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester keeps every req_* field stable
// while req_valid is high and req_ready is low. resp_valid is a single-cycle
// pulse with no back-pressure; resp_rdata/resp_err are qualified by it.
//
// The slave modport is the LSU. The master modport is the other side, i.e.
// the memory stage driving requests together with the data memory
// answering on mem_rd.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane from the
// memory word, and merges a right-aligned store lane into the old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  assign shamt = {addr_lo, 3'b000};

  // Load path: shift the addressed lane down to bit 0, then extend it.
  always_comb begin
    shifted = rd_word >> shamt;
    ld_data = shifted;
    case (size)
      SZ_BYTE: ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Store path: position the new lane and splice it into the old word.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    lane_data = st_data;
    case (size)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << shamt;
        lane_data = {24'h0, st_data[7:0]} << shamt;
      end
      SZ_HALF: begin
        lane_mask = 32'h0000_FFFF << shamt;
        lane_data = {16'h0, st_data[15:0]} << shamt;
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = st_data;
      end
    endcase
    merged = (rd_word & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory-stage request at a time, reads the
// data memory (combinational read), performs read-modify-write for sub-word
// stores, and rejects misaligned or out-of-range accesses before any memory
// cycle. state_dbg exposes the FSM state.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus,
  output lsu_state_e          state_dbg
);

  localparam logic [29:0] IDX_LIMIT = 30'(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wr_word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign accept  = bus.req_valid & (state_q == IDLE);
  assign req_err = (bus.req_size == SZ_ILLEGAL)
                 | access_misaligned(bus.req_size, bus.req_addr[1:0])
                 | (bus.req_addr[31:2] >= IDX_LIMIT);

  lsu_lane_align u_align (
    .rd_word     (bus.mem_rd),
    .st_data     (wr_word_q),
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: errors go straight to RESP, word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                     state_d = RESP;
          else if (!bus.req_we)            state_d = RD;
          else if (bus.req_size == SZ_WORD) state_d = WR;
          else                             state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, RMW merge and response registers (held between pulses).
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= 32'h0;
      wr_word_q <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q      <= bus.req_we;
            size_q    <= bus.req_size;
            uns_q     <= bus.req_unsigned;
            addr_q    <= bus.req_addr;
            wr_word_q <= bus.req_wdata;
            if (req_err) begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
            end
          end
        end
        RD: begin
          if (we_q) begin
            wr_word_q <= merged;
          end else begin
            rdata_q <= ld_data;
            err_q   <= 1'b0;
          end
        end
        WR: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  // Reset in the WR cycle must suppress the write, hence the direct gate.
  assign bus.mem_we     = (state_q == WR) & ~reset;
  assign bus.mem_a      = ((state_q == RD) || (state_q == WR)) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wd     = (state_q == WR) ? wr_word_q : 32'h0;
  assign state_dbg      = state_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the datapath and drives the word-wide, single-write-enable data memory.
- Supports byte, halfword and word access, with sign or zero extension on loads.
- Performs read-modify-write for sub-word stores, and flags misaligned or out-of-range accesses without touching memory.
- Sits between the processor's memory stage and the data memory (combinational read, synchronous write).

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; word index req_addr[31:2] >= MEM_WORDS is an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  access rejected, qualified by resp_valid
- mem_we  out  1  memory write enable
- mem_a  out  32  word-aligned memory address {addr[31:2],2'b00}
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational from mem_a)

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - req_ready=1 after reset deasserts.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0.
- States:
  - IDLE: req_ready=1. Accepting on req_valid&req_ready latches we, size, unsigned, addr, wdata, then checks the access:
    - error (size==11; half with addr[0]=1; word with addr[1:0]!=0; word index >= MEM_WORDS) -> RESP with err.
    - load -> RD.
    - word store -> WR.
    - byte/half store -> RD.
  - RD: mem_a = aligned address, mem_we=0.
    - Load: extract lane, extend, latch result -> RESP.
    - Store: merge new lane into mem_rd, latch merged word -> WR.
  - WR: mem_a = aligned address, mem_wd = full word or merged word, mem_we=1 for exactly this cycle -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. A new request can be accepted on the cycle after RESP.
- Outside RD/WR: mem_a=0, mem_wd=0, mem_we=0.
- Lanes: little-endian; byte k = bits [8k+7:8k]; half at addr[1] selects [15:0] or [31:16].
- Sign extension copies bit 7 or 15; zero extension fills with 0.
- Latency from accept cycle T to resp_valid:
  - load: T+2.
  - word store: T+2.
  - sub-word store: T+3.
  - error: T+1.
- req_ready=0 in every non-IDLE state. Requests arriving there are ignored; the requester holds them.
- resp_rdata/resp_err hold their last value between pulses and are only meaningful with resp_valid.
- Erroring access: mem_we never asserted, no RD cycle.
- Reset mid-operation: abort to IDLE with no memory write. mem_we = (state==WR) & ~reset, so reset asserted in the WR cycle suppresses the write.
- Address wrap: none; the top-word check covers out-of-range.

Decomposition:
- Package lsu_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state encoding IDLE/RD/WR/RESP.
- Sub-module lsu_lane_align (combinational): load extract+extend, and store merge (old word, new data, size, addr[1:0]) -> merged word.

Test Plan:
- Word store 0xDEADBEEF @0x10 -> mem_we high exactly one cycle at T+1, mem_a=0x10, mem_wd=0xDEADBEEF; resp_valid at T+2, err=0, rdata=0.
- Byte loads @0x13 after the above:
  - signed -> rdata=0xFFFFFFDE at T+2.
  - unsigned -> 0x000000DE.
  - signed half @0x10 -> 0xFFFFBEEF.
- Half store 0x00001234 @0x12 over 0xDEADBEEF:
  - RD at T+1, WR at T+2 with mem_wd=0x1234BEEF, resp at T+3.
  - Subsequent word load -> 0x1234BEEF.
- Misaligned word load @0x02, half store @0x11, size=11 -> resp_valid at T+1 with err=1; mem_we never high, memory unchanged.
- Word load @0x100 (index 64, MEM_WORDS=64) -> err=1; @0xFC -> normal load, err=0.
- Reset during WR of a byte store @0x10 -> mem_we stays 0, word unchanged, no resp_valid, req_ready=1 the cycle after reset drops.
- req_valid held across back-to-back loads -> second accept exactly one cycle after the first resp_valid.
